// File: rtl/sequenciador_de_instrucoes.sv
// Instruction FIFO plus T0..T3 step sequencer feeding logica_de_controle.
// Optional build macro STEP_DEBUG_EN adds a single-step input that gates every FSM transition.
module sequenciador_de_instrucoes #(
  parameter int DEPTH = 4,
  parameter int IW    = 9
) (
  input  logic                         clock,
  input  logic                         resetn,
  input  logic [IW-1:0]                iin,
  input  logic                         iin_valid,
`ifdef STEP_DEBUG_EN
  input  logic                         step,
`endif
  output logic                         iin_ready,
  output logic [1:0]                   counter,
  output logic [IW-1:0]                instr,
  output logic                         busy,
  output logic                         done,
  output logic [$clog2(DEPTH+1)-1:0]   fifo_count
);

  // state | meaning
  // IDLE  | T0: pop the FIFO head into instr when one is available
  // T1    | decode; ALU ops go to T2, OUT/LDI/REP to T3, undefined opcodes finish here
  // T2    | ALU execute step
  // T3    | final step; done pulses, always returns through IDLE
  typedef enum logic [1:0] {
    S_IDLE = 2'b00,
    S_T1   = 2'b01,
    S_T2   = 2'b10,
    S_T3   = 2'b11
  } state_t;

  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);

  state_t          state, state_nxt;
  logic [IW-1:0]   mem [DEPTH];
  logic [AW-1:0]   wr_ptr, rd_ptr;
  logic [CW-1:0]   cnt;
  logic            push, pop, adv, full, empty;
  logic [2:0]      opcode;
  logic            op_alu, op_undef;

`ifdef STEP_DEBUG_EN
  assign adv = step;
`else
  assign adv = 1'b1;
`endif

  assign full      = (cnt == CW'(DEPTH));
  assign empty     = (cnt == '0);
  assign iin_ready = !full;
  // ready depends on full only, so a simultaneous pop never frees a slot for the same edge
  assign push      = iin_valid && !full;
  assign pop       = adv && (state == S_IDLE) && !empty;

  assign opcode   = instr[IW-1:IW-3];
  assign op_alu   = (opcode == 3'b000) || (opcode == 3'b001) || (opcode == 3'b010);
  assign op_undef = (opcode == 3'b011) || (opcode == 3'b110);

  assign counter    = state;
  assign busy       = (state != S_IDLE);
  assign fifo_count = cnt;

  always_ff @(posedge clock) begin
    if (push) mem[wr_ptr] <= iin;
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   cnt <= cnt + 1'b1;
        2'b01:   cnt <= cnt - 1'b1;
        default: cnt <= cnt;
      endcase
    end
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state <= S_IDLE;
      instr <= '0;
    end else begin
      state <= state_nxt;
      if (pop) instr <= mem[rd_ptr];
    end
  end

  always_comb begin
    state_nxt = state;
    done      = 1'b0;
    if (adv) begin
      case (state)
        S_IDLE: if (!empty) state_nxt = S_T1;
        S_T1: begin
          if (op_alu) begin
            state_nxt = S_T2;
          end else if (op_undef) begin
            state_nxt = S_IDLE;
            done      = 1'b1;
          end else begin
            state_nxt = S_T3;
          end
        end
        S_T2: state_nxt = S_T3;
        S_T3: begin
          state_nxt = S_IDLE;
          done      = 1'b1;
        end
        default: state_nxt = S_IDLE;
      endcase
    end
  end

endmodule
